// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester, ROB-control and CDB signals of the CDB arbiter
interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [TAG_W-1:0]               head_ptr;
  logic                           ld_pc;
  logic                           flush_in_prog;
  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_tag;
  logic [DATA_W-1:0]              cdb_data;
  logic [ROB_DEPTH-1:0]           set_rob_valid;
  modport master (
    input  req_valid, req_tag, req_data, head_ptr, ld_pc, flush_in_prog,
    output req_ready, cdb_valid, cdb_tag, cdb_data, set_rob_valid
  );
  modport slave (
    output req_valid, req_tag, req_data, head_ptr, ld_pc, flush_in_prog,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, set_rob_valid
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: oldest-first CDB arbiter with flush drain; CDB_ARB_PERF_EN adds grant/conflict counters
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  cdb_arbiter_if.master             bus
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]  grant_cnt,
  output logic [15:0]               conflict_cnt
`endif
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [0:0]         state;
  logic               flush;
  logic               run;
  logic               found;
  logic [TAG_W-1:0]   best_age;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_data;
  logic [NUM_REQ-1:0] win_oh;
  logic               grant;
  assign flush = bus.ld_pc | bus.flush_in_prog;
  // DRAIN hands back to RUN in the very cycle flush drops, so grants resume immediately
  assign run   = (state == RUN) || !flush;
  assign grant = found && run && !flush && !rst;
  assign bus.req_ready     = grant ? win_oh : '0;
  assign bus.set_rob_valid = bus.cdb_valid ? (ROB_DEPTH'(1) << bus.cdb_tag) : '0;
  // pick the valid requester with the smallest head-relative age; strict compare keeps the lowest index on ties
  always_comb begin
    found    = 1'b0;
    best_age = '0;
    win_tag  = '0;
    win_data = '0;
    win_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && (!found || TAG_W'(bus.req_tag[i] - bus.head_ptr) < best_age)) begin
        found    = 1'b1;
        best_age = TAG_W'(bus.req_tag[i] - bus.head_ptr);
        win_tag  = bus.req_tag[i];
        win_data = bus.req_data[i];
        win_oh   = NUM_REQ'(1) << i;
      end
    end
  end
  // CDB register and RUN/DRAIN state; flush always empties the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
    end else begin
      state         <= flush ? DRAIN : RUN;
      bus.cdb_valid <= grant;
      if (grant) begin
        bus.cdb_tag  <= win_tag;
        bus.cdb_data <= win_data;
      end
    end
  end
`ifdef CDB_ARB_PERF_EN
  // saturating per-requester grant counts and multi-request conflict count
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      if ($countones(bus.req_valid) >= 2 && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized check of cdb_arbiter against an age-ordering model
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cdb_arbiter_if #(.NUM_REQ(N), .ROB_DEPTH(D), .DATA_W(DW)) bus ();
`ifdef CDB_ARB_PERF_EN
  logic [N-1:0][15:0] gc;
  logic [15:0]        cc;
`endif
  cdb_arbiter #(.NUM_REQ(N), .ROB_DEPTH(D), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CDB_ARB_PERF_EN
    ,
    .grant_cnt(gc),
    .conflict_cnt(cc)
`endif
  );
  int vec  = 0;
  int errs = 0;
  logic chk_on = 1'b0;
  logic [N-1:0] g_last = '0;
  logic         mv = 1'b0;
  int           mt = 0;
  logic [31:0]  md = '0;
  int           mg [N];
  int           mc = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // oldest = smallest (tag - head) mod D among valid requesters; ties favour lower index
  function automatic logic [N-1:0] model_grant();
    int best = -1;
    int ba = D;
    if (rst || bus.ld_pc || bus.flush_in_prog) return '0;
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i]) begin
        int age = (int'(bus.req_tag[i]) - int'(bus.head_ptr) + D) % D;
        if (age < ba) begin
          ba = age;
          best = i;
        end
      end
    return best < 0 ? '0 : N'(1) << best;
  endfunction
  always @(posedge clk) begin
    int nv;
    g_last = model_grant();
    nv = 0;
    for (int i = 0; i < N; i++) nv += int'(bus.req_valid[i]);
    if (rst) begin
      mv = 1'b0; mt = 0; md = '0; mc = 0;
      for (int i = 0; i < N; i++) mg[i] = 0;
    end else begin
      mv = |g_last;
      for (int i = 0; i < N; i++)
        if (g_last[i]) begin
          mt = int'(bus.req_tag[i]);
          md = bus.req_data[i];
          mg[i]++;
        end
      if (nv >= 2) mc++;
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      check("req_ready", 64'(bus.req_ready), 64'(model_grant()));
      check("cdb_valid", 64'(bus.cdb_valid), 64'(mv));
      check("set_rob_valid", 64'(bus.set_rob_valid), mv ? 64'(1) << mt : 64'd0);
      if (mv) begin
        check("cdb_tag", 64'(bus.cdb_tag), 64'(mt));
        check("cdb_data", 64'(bus.cdb_data), 64'(md));
      end
`ifdef CDB_ARB_PERF_EN
      for (int i = 0; i < N; i++) check("grant_cnt", 64'(gc[i]), 64'(mg[i]));
      check("conflict_cnt", 64'(cc), 64'(mc));
`endif
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input int tag, input logic [31:0] data);
    bus.req_valid[i] = 1'b1;
    bus.req_tag[i]   = 3'(tag);
    bus.req_data[i]  = data;
  endtask
  initial begin
    int order [4] = '{2, 1, 3, 0};
    bus.req_valid = '1;
    bus.req_tag = '0;
    bus.req_data = '0;
    bus.head_ptr = '0;
    bus.ld_pc = 1'b0;
    bus.flush_in_prog = 1'b0;
    tick();
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    check("rst_cdb_data", 64'(bus.cdb_data), 64'd0);
    check("rst_set_rob", 64'(bus.set_rob_valid), 64'd0);
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    set_req(0, 3, 32'hDEAD_BEEF);
    @(negedge clk);
    check("single_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_valid", 64'(bus.cdb_valid), 64'd1);
    check("single_tag", 64'(bus.cdb_tag), 64'd3);
    check("single_data", 64'(bus.cdb_data), 64'hDEAD_BEEF);
    check("single_set_rob", 64'(bus.set_rob_valid), 64'b0000_1000);
    tick();
    bus.head_ptr = 3'd5;
    set_req(0, 1, 32'h10);
    set_req(1, 6, 32'h11);
    set_req(2, 5, 32'h12);
    set_req(3, 7, 32'h13);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("age_order", 64'(bus.req_ready), 64'(1) << order[k]);
      tick();
      bus.req_valid[order[k]] = 1'b0;
    end
    bus.head_ptr = 3'd6;
    set_req(1, 0, 32'h21);
    set_req(2, 7, 32'h22);
    @(negedge clk);
    check("wrap_first", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    check("wrap_tag7", 64'(bus.cdb_tag), 64'd7);
    check("wrap_second", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("wrap_tag0", 64'(bus.cdb_tag), 64'd0);
    tick();
    set_req(0, 2, 32'h33);
    bus.ld_pc = 1'b1;
    @(negedge clk);
    check("flush_ldpc_ready", 64'(bus.req_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.ld_pc = 1'b0;
      bus.flush_in_prog = 1'b1;
      @(negedge clk);
      check("flush_ready", 64'(bus.req_ready), 64'd0);
      check("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    end
    tick();
    bus.flush_in_prog = 1'b0;
    @(negedge clk);
    check("resume_ready", 64'(bus.req_ready), 64'b0001);
    check("resume_cdb_idle", 64'(bus.cdb_valid), 64'd0);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("resume_cdb_valid", 64'(bus.cdb_valid), 64'd1);
    check("resume_cdb_tag", 64'(bus.cdb_tag), 64'd2);
    tick();
    bus.head_ptr = '0;
    set_req(0, 4, 32'h44);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 64'(bus.req_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cdb", 64'(bus.cdb_valid), 64'd0);
    check("rst_mid_regrant", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("rst_mid_tag", 64'(bus.cdb_tag), 64'd4);
`ifdef CDB_ARB_PERF_EN
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1, 32'h1);
    set_req(1, 2, 32'h2);
    set_req(2, 3, 32'h3);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.req_valid[k] = 1'b0;
    end
    @(negedge clk);
    check("perf_grant_total", 64'(int'(gc[0]) + int'(gc[1]) + int'(gc[2]) + int'(gc[3])), 64'd3);
    check("perf_conflict", 64'(cc), 64'd2);
`endif
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (g_last[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(2) == 0)
          set_req(i, int'($urandom_range(D - 1)), $urandom);
      end
      if ($urandom_range(7) == 0) bus.head_ptr = 3'($urandom_range(D - 1));
      bus.ld_pc = ($urandom_range(15) == 0);
      if ($urandom_range(9) == 0) bus.flush_in_prog = ~bus.flush_in_prog;
      rst = ($urandom_range(99) == 0);
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Age-ordered arbiter and sequencer for the common data bus (CDB) that completes ROB entries. Up to NUM_REQ functional-unit/reservation-station requesters present a completed result tagged with its ROB index; each cycle the arbiter grants the one whose ROB entry is oldest relative to the ROB head pointer. It registers the winner onto the CDB and drives the one-hot `set_rob_valid` vector into the ROB. It also blocks and drains the bus while the ROB signals a branch-mispredict flush.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (ALU, CMP/branch, load, store)
- ROB_DEPTH, 8, ROB entries; tag width TAG_W = $clog2(ROB_DEPTH) = 3
- DATA_W, 32, result width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i holds a completed result
- req_tag  in  NUM_REQ x TAG_W  ROB index of requester i's result
- req_data  in  NUM_REQ x DATA_W  result value of requester i
- req_ready  out  NUM_REQ  one-hot grant; requester i's result is accepted this cycle
- head_ptr  in  TAG_W  ROB head pointer
- ld_pc  in  1  ROB mispredict detected this cycle
- flush_in_prog  in  1  ROB flush in progress
- cdb_valid  out  1  CDB carries a result
- cdb_tag  out  TAG_W  ROB index on CDB
- cdb_data  out  DATA_W  value on CDB
- set_rob_valid  out  ROB_DEPTH  one-hot decode of cdb_tag, gated by cdb_valid
- grant_cnt  out  NUM_REQ x 16  per-requester grant count (only with CDB_ARB_PERF_EN)
- conflict_cnt  out  16  count of cycles with at least 2 valid requests (only with CDB_ARB_PERF_EN)

## Operation
- Age of requester i: `age_i = (req_tag_i - head_ptr) mod ROB_DEPTH`, computed in TAG_W-bit unsigned arithmetic, so it wraps naturally.
- Winner: the valid requester with the smallest age. On equal age, the lowest index wins; equal age is illegal but the outcome is still deterministic.
- req_ready is combinational. It is asserted only for the winner, only in state RUN, and only when `flush = ld_pc | flush_in_prog` is low.
- Requester protocol:
  - Once req_valid is high, the requester holds req_valid, req_tag and req_data stable until it samples req_ready high at a clock edge.
  - The requester may present a new result in the cycle after that edge.
- FSM, two states:
  - RUN (reset state): a grant loads the CDB register; with no grant, cdb_valid is loaded with 0. Go to DRAIN when flush=1.
  - DRAIN: no grants; cdb_valid is loaded with 0. Go to RUN on the first cycle where flush=0. Grants resume in that same cycle.
- Flush priority: when flush=1, the CDB register is loaded with cdb_valid=0 in both states, and any request in that cycle is not granted.
- Requesters are responsible for discarding their own flushed work; the arbiter does not filter requests by tag.
- Starvation: none. The oldest entry always wins and the ROB head only advances.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, set_rob_valid=0, state=RUN, counters=0. req_ready=0 while rst=1.
- Latency: a grant in cycle N produces cdb_valid/tag/data and set_rob_valid in cycle N+1.
- Throughput: one result per cycle; back-to-back grants to the same requester are allowed.
- set_rob_valid is combinational from the CDB register: exactly one bit is set when cdb_valid=1, all zero otherwise.
- A result already registered when ld_pc rises is still presented for that one cycle; the ROB flush clears the entry.
- Reset mid-broadcast: cdb_valid=0 in the cycle after the rst edge; any pending grant is lost and requesters must re-present.
- Wrap-around example: head_ptr=6, tags 7 and 0 give ages 1 and 2, so tag 7 wins.

## Configuration
- `CDB_ARB_PERF_EN` defined:
  - grant_cnt[i] increments, saturating at 16'hFFFF, on each cycle req_ready[i]=1.
  - conflict_cnt increments, saturating, on each cycle where popcount(req_valid) ≥ 2, whether or not a flush is active.
  - Both counters reset to 0.
- Not defined: the counter ports are absent, with no counter logic.

## Test plan
- Single requester: req_valid[0]=1, tag=3, data=32'hDEAD_BEEF, head=0 -> req_ready[0]=1 the same cycle; next cycle cdb_valid=1, cdb_tag=3, cdb_data=32'hDEAD_BEEF, set_rob_valid=8'b0000_1000.
- Age ordering: head=5; requesters 0..3 with tags 1, 6, 5, 7 all valid -> grants over successive cycles go to requesters 2, 1, 3, 0; requesters hold until granted.
- Wrap: head=6, tags 0 (req 1) and 7 (req 2) -> req 2 granted first, cdb_tag=7, then cdb_tag=0.
- Flush: ld_pc=1 for one cycle, then flush_in_prog=1 for 3 cycles, with req_valid held high throughout -> req_ready=0 and cdb_valid=0 for all 4 cycles; grant in the first cycle with flush=0, CDB valid the cycle after.
- Reset mid-stream: rst=1 during a cycle with a grant -> req_ready=0, then cdb_valid=0 the next cycle; after rst drops, the held request is granted normally.
- `CDB_ARB_PERF_EN`: 3 requesters valid for 3 cycles with no flush -> grant_cnt total = 3 and conflict_cnt = 2: 3 simultaneous valids in cycle 1, 2 in cycle 2, 1 in cycle 3, since each requester drops req_valid after its grant.
